// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage.
//   - Bus widths for the ID->EX, EX->MEM and EX->RF buses.
//   - Stall-vector width and the stage indices EX looks at.
//   - Packed structs that give names to the bus fields, MSB first.
//   - Divider FSM state type and a 32-bit magnitude helper.
package ex_stage_pkg;

  localparam int unsigned STALL_WD     = 6;
  localparam int unsigned ID_TO_EX_WD  = 231;
  localparam int unsigned EX_TO_MEM_WD = 142;
  localparam int unsigned EX_TO_RF_WD  = 104;

  // Stall vector: bit = 1 means Stop
  localparam logic        STOP         = 1'b1;
  localparam logic        NO_STOP      = 1'b0;
  localparam int unsigned STALL_EX     = 2;
  localparam int unsigned STALL_MEM    = 3;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  typedef struct packed {
    logic mfhi;
    logic mflo;
    logic mthi;
    logic mtlo;
    logic mult;
    logic multu;
    logic div;
    logic divu;
  } hilo_op_t;

  typedef struct packed {
    logic op_add;
    logic op_sub;
    logic op_slt;
    logic op_sltu;
    logic op_and;
    logic op_nor;
    logic op_or;
    logic op_xor;
    logic op_sll;
    logic op_srl;
    logic op_sra;
    logic op_lui;
  } alu_op_t;

  typedef struct packed {
    hilo_op_t    hilo_op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic [31:0] inst;
    alu_op_t     alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;
  } ex_to_mem_t;

  typedef struct packed {
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_rf_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative radix-2 restoring divider with sign handling.
//   clk, rst    : clock, synchronous active-high reset (forces IDLE, clears result)
//   start       : divide requested by the instruction sitting in EX
//   signed_op   : 1 = div (signed), 0 = divu
//   dividend    : numerator
//   divisor     : denominator
//   stall_hold  : keep the finished result while EX is stalled
//   busy        : stall request (issuing IDLE cycle plus every BUSY cycle)
//   done        : quotient/remainder valid this cycle
//   quotient    : signed-corrected quotient, 0 unless done
//   remainder   : signed-corrected remainder, 0 unless done
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        stall_hold,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dsr_q, dsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [32:0]      shifted;
  logic [32:0]      trial;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start)               state_d = DIV_BUSY;
      DIV_BUSY: if (cnt_q == LAST_STEP)  state_d = DIV_DONE;
      DIV_DONE: if (!stall_hold)         state_d = DIV_IDLE;
      default:                           state_d = DIV_IDLE;
    endcase
  end

  // Datapath: operands are stored as magnitudes; signs are applied on output.
  // A zero divisor needs no special case: every trial subtraction succeeds,
  // giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    shifted   = {rem_q, quo_q[31]};
    trial     = shifted - {1'b0, dsr_q};
    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = signed_op ? abs32(dividend) : dividend;
          dsr_d     = signed_op ? abs32(divisor)  : divisor;
          neg_quo_d = signed_op & (dividend[31] ^ divisor[31]);
          neg_rem_d = signed_op & dividend[31];
        end
      end
      DIV_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (shifted >= {1'b0, dsr_q}) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Output logic
  always_comb begin
    busy      = ((state_q == DIV_IDLE) && start) || (state_q == DIV_BUSY);
    done      = (state_q == DIV_DONE);
    quotient  = '0;
    remainder = '0;
    if (done) begin
      quotient  = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
      remainder = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registers the decode bus, runs the ALU, handles HI/LO ops
// (single-cycle multiply, iterative divide) and issues data SRAM requests.
//   clk, rst        : clock, synchronous active-high reset
//   stall           : stall vector, bit = 1 stops that stage (EX uses [2], [3])
//   id_to_ex_bus    : instruction bundle from decode
//   ex_to_mem_bus   : result bundle to MEM
//   ex_to_rf_bus    : forwarding bundle back to decode
//   data_sram_*     : data SRAM request (enable, byte write enables, addr, wdata)
//   stallreq_for_ex : held high while a divide is in flight
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t   id_ex_q, id_ex_d;
  logic [31:0] alu_src1, alu_src2, alu_res;
  logic [4:0]  shamt;
  logic [63:0] prod_s, prod_u;
  logic        div_any, div_wb, div_busy, div_done;
  logic [31:0] div_quo, div_rem;
  logic        hi_we, lo_we;
  logic [31:0] hi_val, lo_val, ex_result;
  ex_to_mem_t  mem_bus;
  ex_to_rf_t   rf_bus;
  logic        unused_bits;

  // Opcode/register fields of inst and the other stages' stall bits are
  // consumed elsewhere in the pipeline.
  assign unused_bits = ^{id_ex_q.inst[31:16], stall[5:4], stall[1:0]};

  // Input register: bubble when EX stops but MEM runs, load when EX runs.
  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP)
      id_ex_d = '0;
    else if (stall[STALL_EX] == NO_STOP)
      id_ex_d = id_to_ex_t'(id_to_ex_bus);
  end

  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  // ALU operand select and operation
  always_comb begin
    alu_src1 = '0;
    if      (id_ex_q.src1[0]) alu_src1 = id_ex_q.rdata1;
    else if (id_ex_q.src1[1]) alu_src1 = id_ex_q.pc;
    else if (id_ex_q.src1[2]) alu_src1 = {27'b0, id_ex_q.inst[10:6]};

    alu_src2 = '0;
    if      (id_ex_q.src2[0]) alu_src2 = id_ex_q.rdata2;
    else if (id_ex_q.src2[1]) alu_src2 = {{16{id_ex_q.inst[15]}}, id_ex_q.inst[15:0]};
    else if (id_ex_q.src2[2]) alu_src2 = 32'd8;
    else if (id_ex_q.src2[3]) alu_src2 = {16'b0, id_ex_q.inst[15:0]};

    shamt   = alu_src1[4:0];
    alu_res = '0;
    if      (id_ex_q.alu_op.op_add)  alu_res = alu_src1 + alu_src2;
    else if (id_ex_q.alu_op.op_sub)  alu_res = alu_src1 - alu_src2;
    else if (id_ex_q.alu_op.op_slt)  alu_res = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
    else if (id_ex_q.alu_op.op_sltu) alu_res = {31'b0, alu_src1 < alu_src2};
    else if (id_ex_q.alu_op.op_and)  alu_res = alu_src1 & alu_src2;
    else if (id_ex_q.alu_op.op_nor)  alu_res = ~(alu_src1 | alu_src2);
    else if (id_ex_q.alu_op.op_or)   alu_res = alu_src1 | alu_src2;
    else if (id_ex_q.alu_op.op_xor)  alu_res = alu_src1 ^ alu_src2;
    else if (id_ex_q.alu_op.op_sll)  alu_res = alu_src2 << shamt;
    else if (id_ex_q.alu_op.op_srl)  alu_res = alu_src2 >> shamt;
    else if (id_ex_q.alu_op.op_sra)  alu_res = $unsigned($signed(alu_src2) >>> shamt);
    else if (id_ex_q.alu_op.op_lui)  alu_res = {alu_src2[15:0], 16'b0};
  end

  // Both products are taken as 64x64 with the operands pre-extended, so the
  // low 64 bits are exact for signed and unsigned alike.
  assign prod_s = {{32{id_ex_q.rdata1[31]}}, id_ex_q.rdata1} *
                  {{32{id_ex_q.rdata2[31]}}, id_ex_q.rdata2};
  assign prod_u = {32'b0, id_ex_q.rdata1} * {32'b0, id_ex_q.rdata2};

  assign div_any = id_ex_q.hilo_op.div | id_ex_q.hilo_op.divu;

  div_iter #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_any),
    .signed_op  (id_ex_q.hilo_op.div),
    .dividend   (id_ex_q.rdata1),
    .divisor    (id_ex_q.rdata2),
    .stall_hold (stall[STALL_EX]),
    .busy       (div_busy),
    .done       (div_done),
    .quotient   (div_quo),
    .remainder  (div_rem)
  );

  // HI/LO write-back and result select
  always_comb begin
    div_wb = div_any & div_done;
    hi_we  = id_ex_q.hilo_op.mthi | id_ex_q.hilo_op.mult | id_ex_q.hilo_op.multu | div_wb;
    lo_we  = id_ex_q.hilo_op.mtlo | id_ex_q.hilo_op.mult | id_ex_q.hilo_op.multu | div_wb;

    hi_val = '0;
    if      (id_ex_q.hilo_op.mthi)  hi_val = id_ex_q.rdata1;
    else if (id_ex_q.hilo_op.mult)  hi_val = prod_s[63:32];
    else if (id_ex_q.hilo_op.multu) hi_val = prod_u[63:32];
    else if (div_wb)                hi_val = div_rem;

    lo_val = '0;
    if      (id_ex_q.hilo_op.mtlo)  lo_val = id_ex_q.rdata1;
    else if (id_ex_q.hilo_op.mult)  lo_val = prod_s[31:0];
    else if (id_ex_q.hilo_op.multu) lo_val = prod_u[31:0];
    else if (div_wb)                lo_val = div_quo;

    ex_result = alu_res;
    if      (id_ex_q.hilo_op.mfhi) ex_result = id_ex_q.hi;
    else if (id_ex_q.hilo_op.mflo) ex_result = id_ex_q.lo;
  end

  // Output bundles
  always_comb begin
    mem_bus.pc         = id_ex_q.pc;
    mem_bus.ram_en     = id_ex_q.ram_en;
    mem_bus.ram_wen    = id_ex_q.ram_wen;
    mem_bus.sel_rf_res = id_ex_q.sel_rf_res;
    mem_bus.rf_we      = id_ex_q.rf_we;
    mem_bus.rf_waddr   = id_ex_q.rf_waddr;
    mem_bus.ex_result  = ex_result;
    mem_bus.hi_we      = hi_we;
    mem_bus.hi         = hi_val;
    mem_bus.lo_we      = lo_we;
    mem_bus.lo         = lo_val;

    // A load's ALU result is an address, never forwardable data.
    rf_bus.hi_we       = hi_we;
    rf_bus.hi          = hi_val;
    rf_bus.lo_we       = lo_we;
    rf_bus.lo          = lo_val;
    rf_bus.rf_we       = id_ex_q.rf_we & ~id_ex_q.sel_rf_res;
    rf_bus.rf_waddr    = id_ex_q.rf_waddr;
    rf_bus.ex_result   = ex_result;
  end

  assign ex_to_mem_bus   = mem_bus;
  assign ex_to_rf_bus    = rf_bus;
  assign data_sram_en    = id_ex_q.ram_en;
  assign data_sram_wen   = id_ex_q.ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = id_ex_q.rdata2;
  assign stallreq_for_ex = div_busy;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [230:0] id_to_ex_bus;
  logic [141:0] ex_to_mem_bus;
  logic [103:0] ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [230:0] mk(
    input logic [7:0]  hilo, input logic [31:0] hi, input logic [31:0] lo,
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] alu,
    input logic [2:0]  s1, input logic [3:0] s2, input logic ram_en,
    input logic [3:0]  wen, input logic rf_we, input logic [4:0] waddr,
    input logic sel, input logic [31:0] r1, input logic [31:0] r2);
    return {hilo, hi, lo, pc, inst, alu, s1, s2, ram_en, wen, rf_we, waddr, sel, r1, r2};
  endfunction

  // Reference ALU: k indexes add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui; 12 = no op
  function automatic logic [31:0] alu_model(input int k, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = a[4:0];
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << sh;
      9:  return b >> sh;
      10: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      11: return {b[15:0], 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  // Issue a divide, measure the stall window and check the DONE-cycle result.
  // Leaves the divider in DONE with EX stalled.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    int n;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (mb == 0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    id_to_ex_bus = mk(sgn ? 8'b0000_0010 : 8'b0000_0001, '0, '0, 32'h0040_0000, '0, '0,
                      3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
    stall = 6'b000000;
    tick();
    stall = 6'b001111;
    n = 0;
    while (stallreq_for_ex && n < 40) begin
      n++;
      tick();
    end
    check({tag, "_stall_cycles"}, 144'(n), 144'(33));
    check({tag, "_result"}, 144'(ex_to_rf_bus), 144'({1'b1, r, 1'b1, q, 1'b0, 5'd0, 32'd0}));
  endtask

  logic [31:0]  r1, r2, pc, inst, hv, lv, a, b, res;
  logic [2:0]   s1oh;
  logic [3:0]   s2oh, wen;
  logic [11:0]  alu;
  logic [4:0]   waddr;
  logic         ram_en, rf_we, sel;
  logic [63:0]  p;
  logic [103:0] held;
  int           k, s1, s2;

  initial begin
    rst = 1'b1;
    stall = 6'b000000;
    id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
    tick();
    check("reset_mem_bus", 144'(ex_to_mem_bus), 144'(0));
    check("reset_rf_bus", 144'(ex_to_rf_bus), 144'(0));
    check("reset_sram_stall", 144'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_ex}), 144'(0));
    rst = 1'b0;

    // addiu overflow wraps without trap
    id_to_ex_bus = mk('0, '0, '0, 32'h0040_0010, 32'h2422_0001, 12'h800, 3'b001, 4'b0010,
                      1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h7FFF_FFFF, 32'h0);
    tick();
    check("addiu_rf_bus", 144'(ex_to_rf_bus), 144'({1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd3, 32'h8000_0000}));
    check("addiu_stallreq", 144'(stallreq_for_ex), 144'(0));

    // sra by sa field
    id_to_ex_bus = mk('0, '0, '0, '0, 32'h0000_0100, 12'h002, 3'b100, 4'b0001,
                      1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h8000_0000);
    tick();
    check("sra", 144'(ex_to_rf_bus[31:0]), 144'(32'hF800_0000));

    // sltu 1 < FFFF_FFFF
    id_to_ex_bus = mk('0, '0, '0, '0, '0, 12'h100, 3'b001, 4'b0001,
                      1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h1, 32'hFFFF_FFFF);
    tick();
    check("sltu", 144'(ex_to_rf_bus[31:0]), 144'(32'h1));

    // sw with negative offset
    id_to_ex_bus = mk('0, '0, '0, '0, 32'hAC02_FFFC, 12'h800, 3'b001, 4'b0010,
                      1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
    tick();
    check("sw_sram", 144'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
          144'({1'b1, 4'hF, 32'h0000_0FFC, 32'hDEAD_BEEF}));

    // EX and MEM both stopped: hold
    id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    stall = 6'b001111;
    tick();
    check("hold_sram", 144'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
          144'({1'b1, 4'hF, 32'h0000_0FFC, 32'hDEAD_BEEF}));

    // EX stopped, MEM running: bubble
    stall = 6'b000111;
    tick();
    check("bubble_rf_bus", 144'(ex_to_rf_bus), 144'(0));
    check("bubble_mem_bus", 144'(ex_to_mem_bus), 144'(0));
    check("bubble_sram_en", 144'(data_sram_en), 144'(0));
    stall = 6'b000000;

    // Randomized ALU / SRAM traffic
    for (int n = 0; n < 48; n++) begin
      k = $urandom_range(0, 12);
      s1 = $urandom_range(0, 2);
      s2 = $urandom_range(0, 3);
      r1 = $urandom; r2 = $urandom; pc = $urandom; inst = $urandom;
      hv = $urandom; lv = $urandom;
      ram_en = 1'($urandom_range(0, 1)); wen = 4'($urandom);
      rf_we = 1'($urandom_range(0, 1)); sel = 1'($urandom_range(0, 1));
      waddr = 5'($urandom);
      alu = '0;
      if (k < 12) alu[11-k] = 1'b1;
      s1oh = '0; s1oh[s1] = 1'b1;
      s2oh = '0; s2oh[s2] = 1'b1;
      a = (s1 == 0) ? r1 : (s1 == 1) ? pc : {27'b0, inst[10:6]};
      case (s2)
        0: b = r2;
        1: b = {{16{inst[15]}}, inst[15:0]};
        2: b = 32'd8;
        default: b = {16'b0, inst[15:0]};
      endcase
      res = alu_model(k, a, b);
      id_to_ex_bus = mk('0, hv, lv, pc, inst, alu, s1oh, s2oh, ram_en, wen, rf_we, waddr, sel, r1, r2);
      tick();
      check($sformatf("alu%0d_mem_bus", k), 144'(ex_to_mem_bus),
            144'({pc, ram_en, wen, sel, rf_we, waddr, res, 1'b0, 32'd0, 1'b0, 32'd0}));
      check($sformatf("alu%0d_rf_bus", k), 144'(ex_to_rf_bus),
            144'({1'b0, 32'd0, 1'b0, 32'd0, rf_we & ~sel, waddr, res}));
      check($sformatf("alu%0d_sram", k), 144'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
            144'({ram_en, wen, res, r2}));
    end

    // Multiplies and HI/LO moves
    for (int n = 0; n < 6; n++) begin
      r1 = $urandom; r2 = $urandom;
      if (n == 0) begin r1 = 32'h8000_0000; r2 = 32'hFFFF_FFFF; end
      if (n[0]) p = 64'(longint'($signed(r1)) * longint'($signed(r2)));
      else      p = 64'({32'b0, r1}) * 64'({32'b0, r2});
      id_to_ex_bus = mk(n[0] ? 8'b0000_1000 : 8'b0000_0100, '0, '0, '0, '0, '0, 3'b000, 4'b0000,
                        1'b0, 4'h0, 1'b0, 5'd0, 1'b0, r1, r2);
      tick();
      check(n[0] ? "mult" : "multu", 144'(ex_to_rf_bus), 144'({1'b1, p[63:32], 1'b1, p[31:0], 1'b0, 5'd0, 32'd0}));
      check("mult_stallreq", 144'(stallreq_for_ex), 144'(0));
    end
    r1 = $urandom; hv = $urandom; lv = $urandom;
    id_to_ex_bus = mk(8'b0010_0000, hv, lv, '0, '0, '0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, r1, 32'h0);
    tick();
    check("mthi", 144'(ex_to_rf_bus), 144'({1'b1, r1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0}));
    id_to_ex_bus = mk(8'b0001_0000, hv, lv, '0, '0, '0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, r1, 32'h0);
    tick();
    check("mtlo", 144'(ex_to_rf_bus), 144'({1'b0, 32'd0, 1'b1, r1, 1'b0, 5'd0, 32'd0}));
    id_to_ex_bus = mk(8'b1000_0000, hv, lv, '0, '0, '0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, r1, 32'h0);
    tick();
    check("mfhi", 144'(ex_to_rf_bus), 144'({1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd9, hv}));
    id_to_ex_bus = mk(8'b0100_0000, hv, lv, '0, '0, '0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd10, 1'b0, r1, 32'h0);
    tick();
    check("mflo", 144'(ex_to_rf_bus), 144'({1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd10, lv}));

    // Signed divide -7 / 2, then hold DONE for three stalled cycles
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    held = ex_to_rf_bus;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("done_hold_result", 144'(ex_to_rf_bus), 144'({1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFD, 1'b0, 5'd0, 32'd0}));
      check("done_hold_stallreq", 144'(stallreq_for_ex), 144'(0));
    end
    check("done_hold_same", 144'(ex_to_rf_bus), 144'(held));

    // Releasing EX with a new divide must start it at once (DONE -> IDLE)
    run_div("divu_by0", 1'b0, 32'd5, 32'd0);
    stall = 6'b000000;
    id_to_ex_bus = '0;
    tick();
    check("div_release_rf_bus", 144'(ex_to_rf_bus), 144'(0));
    check("div_release_stallreq", 144'(stallreq_for_ex), 144'(0));

    // Randomized divides
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : (n[1] ? 32'($urandom_range(1, 300)) : $urandom);
      if (n == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (n[0]) b = -b;
      run_div($sformatf("rnd_div%0d", n), 1'($urandom_range(0, 1)), a, b);
      stall = 6'b000000;
      id_to_ex_bus = '0;
      tick();
      check("rnd_div_release", 144'(stallreq_for_ex), 144'(0));
    end

    // Reset in BUSY cycle 10
    id_to_ex_bus = mk(8'b0000_0010, '0, '0, 32'h1234, '0, '0, 3'b000, 4'b0000,
                      1'b1, 4'h3, 1'b1, 5'd7, 1'b0, 32'd1000, 32'd7);
    stall = 6'b000000;
    tick();
    stall = 6'b001111;
    repeat (10) tick();
    check("busy10_stallreq", 144'(stallreq_for_ex), 144'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy_mem_bus", 144'(ex_to_mem_bus), 144'(0));
    check("rst_busy_rf_bus", 144'(ex_to_rf_bus), 144'(0));
    check("rst_busy_sram_stall", 144'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_ex}), 144'(0));
    tick();
    check("rst_busy_idle", 144'({stallreq_for_ex, ex_to_rf_bus}), 144'(0));
    stall = 6'b000000;

    // Divider still works after the abort
    run_div("div_after_rst", 1'b1, 32'd100, 32'hFFFF_FFF9);
    stall = 6'b000000;
    id_to_ex_bus = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
